// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run / halt / single-step sequencer for the 5-stage CPU.
//   Generates cpu_en_o, the advance enable for PC and all pipeline registers.
//   Grants the loader access to the instruction and data DRAM write ports
//   only while the core is halted. This block replaces the clk_ld/clk_cpu
//   debug clock mux.
//
// Ports
//   clk_i        CPU clock
//   rst_i        asynchronous reset, active high
//   run_req_i    pulse: enter free-run
//   step_req_i   pulse: run step_cnt_i enabled cycles, then halt
//   halt_req_i   pulse/level: stop the core
//   step_cnt_i   cycle count for step_req_i (a value of 0 runs 1 cycle)
//   bp_en_i      breakpoint enable
//   bp_addr_i    breakpoint PC
//   pc_i         current IF-stage PC
//   ld_req_i     loader requests the DRAM ports
//   cpu_en_o     pipeline advance enable (combinational)
//   ld_gnt_o     loader owns the DRAM ports this cycle (combinational)
//   ld_err_o     1-cycle pulse: ld_req_i was seen while the core was not halted
//   state_o      00 HALT, 01 RUN, 10 STEP
//   bp_hit_o     sticky breakpoint-stop flag
//   cycle_cnt_o  number of cycles with cpu_en_o = 1
//
// Configuration
//   DEBUG_CYCLE_CNT_EN  When defined, the cycle counter is built.
//                       When undefined, cycle_cnt_o is tied to 0.
module debug_run_ctrl #(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_req_i,
  input  logic              step_req_i,
  input  logic              halt_req_i,
  input  logic [STEP_W-1:0] step_cnt_i,
  input  logic              bp_en_i,
  input  logic [31:0]       bp_addr_i,
  input  logic [31:0]       pc_i,
  input  logic              ld_req_i,
  output logic              cpu_en_o,
  output logic              ld_gnt_o,
  output logic              ld_err_o,
  output logic [1:0]        state_o,
  output logic              bp_hit_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  logic [1:0]        state_q,  state_d;
  logic [STEP_W-1:0] ctr_q,    ctr_d;
  logic              arm_q,    arm_d;
  logic              bp_hit_q, bp_hit_d;
  logic              ld_err_q, ld_err_d;
  logic              cpu_en;
  logic              bp_stop;

  // arm_q stays low for the first enabled cycle after a run or step starts.
  // This lets the core resume while it sits on the breakpoint address.
  assign bp_stop = bp_en_i & arm_q & (pc_i == bp_addr_i);

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    arm_d    = arm_q;
    bp_hit_d = bp_hit_q;
    cpu_en   = 1'b0;
    case (state_q)
      ST_HALT: begin
        // halt_req_i outranks step_req_i, which outranks run_req_i.
        // A request that loses is dropped.
        if (halt_req_i) begin
          state_d = ST_HALT;
        end else if (step_req_i) begin
          state_d  = ST_STEP;
          ctr_d    = (step_cnt_i == '0) ? STEP_W'(1) : step_cnt_i;
          arm_d    = 1'b0;
          bp_hit_d = 1'b0;
        end else if (run_req_i) begin
          state_d  = ST_RUN;
          arm_d    = 1'b0;
          bp_hit_d = 1'b0;
        end
      end
      ST_RUN, ST_STEP: begin
        // A run or step request in these states does not reload the counter.
        if (halt_req_i) begin
          state_d = ST_HALT;
        end else if (bp_stop) begin
          // Hold the PC at the breakpoint: the pipeline does not advance
          // this cycle.
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          cpu_en = 1'b1;
          arm_d  = 1'b1;
          if (state_q == ST_STEP) begin
            ctr_d = ctr_q - STEP_W'(1);
            if (ctr_q <= STEP_W'(1)) state_d = ST_HALT;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign ld_err_d = ld_req_i & (state_q != ST_HALT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_HALT;
      ctr_q    <= '0;
      arm_q    <= 1'b0;
      bp_hit_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      arm_q    <= arm_d;
      bp_hit_q <= bp_hit_d;
      ld_err_q <= ld_err_d;
    end
  end

  // The grant also drops in a cycle where a run or step is requested.
  // That keeps the loader from overlapping the first enabled cycle.
  assign ld_gnt_o = ld_req_i & (state_q == ST_HALT) & ~run_req_i & ~step_req_i;
  assign cpu_en_o = cpu_en;
  assign ld_err_o = ld_err_q;
  assign state_o  = state_q;
  assign bp_hit_o = bp_hit_q;

`ifdef DEBUG_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter wraps naturally; it does not saturate.
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (cpu_en) cnt_q <= cnt_d;
  end

  assign cycle_cnt_o = cnt_q;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_debug_run_ctrl.sv
module tb_debug_run_ctrl;
  localparam int STEP_W = 16;
  localparam int CNT_W  = 32;
  localparam logic [31:0] PC0 = 32'h1c00_0000;
  localparam logic [31:0] BPA = 32'h1c00_0010;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic [STEP_W-1:0] step_cnt = '0;
  logic              bp_en = 1'b0;
  logic [31:0]       bp_addr = '0;
  logic [31:0]       pc;
  logic              ld_req = 1'b0;
  logic              cpu_en, ld_gnt, ld_err, bp_hit;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cycle_cnt;

  int nvec = 0;
  int nerr = 0;

  debug_run_ctrl #(.STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .run_req_i(run_req), .step_req_i(step_req),
    .halt_req_i(halt_req), .step_cnt_i(step_cnt), .bp_en_i(bp_en),
    .bp_addr_i(bp_addr), .pc_i(pc), .ld_req_i(ld_req), .cpu_en_o(cpu_en),
    .ld_gnt_o(ld_gnt), .ld_err_o(ld_err), .state_o(state), .bp_hit_o(bp_hit),
    .cycle_cnt_o(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the core's PC: it advances one word per enabled cycle.
  always @(posedge clk or posedge rst) begin
    if (rst)         pc <= PC0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then let the registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] ecnt(input int n);
`ifdef DEBUG_CYCLE_CNT_EN
    return CNT_W'(n);
`else
    return '0;
`endif
  endfunction

  initial begin
    bit done;

    // Reset values.
    tick(); tick();
    chk("rst_state", state, 2'b00);
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_ld_gnt", ld_gnt, 1'b0);
    chk("rst_ld_err", ld_err, 1'b0);
    chk("rst_bp_hit", bp_hit, 1'b0);
    chk("rst_cnt", cycle_cnt, '0);
    rst = 1'b0;
    tick();

    // Free-run: cpu_en stays low in the request cycle and goes high in RUN.
    run_req = 1'b1; #1;
    chk("run_req_cycle_en", cpu_en, 1'b0);
    tick(); run_req = 1'b0; #1;
    chk("run_state", state, 2'b01);
    chk("run_cpu_en", cpu_en, 1'b1);
    tick(); tick(); tick(); tick();        // 4 enabled cycles
    halt_req = 1'b1; #1;
    chk("halt_same_cycle", cpu_en, 1'b0);
    tick(); halt_req = 1'b0; #1;
    chk("halt_state", state, 2'b00);
    chk("cnt_after_run", cycle_cnt, ecnt(4));

    // Loader while halted: granted, core stays stopped.
    ld_req = 1'b1; #1;
    chk("ld_gnt_halt", ld_gnt, 1'b1);
    chk("ld_cpu_en_halt", cpu_en, 1'b0);
    tick();
    chk("ld_err_halt", ld_err, 1'b0);
    ld_req = 1'b0;

    // Step 3: exactly 3 enabled cycles, then HALT.
    step_cnt = 16'd3; step_req = 1'b1;
    tick(); step_req = 1'b0; #1;
    chk("step3_state", state, 2'b10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("step3_en%0d", i), cpu_en, 1'b1);
      tick();
    end
    chk("step3_done_state", state, 2'b00);
    chk("step3_done_en", cpu_en, 1'b0);
    chk("cnt_after_step3", cycle_cnt, ecnt(7));

    // A step count of 0 behaves as a count of 1.
    step_cnt = '0; step_req = 1'b1;
    tick(); step_req = 1'b0; #1;
    chk("step0_en", cpu_en, 1'b1);
    tick();
    chk("step0_state", state, 2'b00);
    chk("cnt_after_step0", cycle_cnt, ecnt(8));

    // Loader while running: no grant, ld_err pulses for one cycle.
    run_req = 1'b1; tick(); run_req = 1'b0;
    ld_req = 1'b1; #1;
    chk("ld_gnt_run", ld_gnt, 1'b0);
    tick(); ld_req = 1'b0;
    chk("ld_err_pulse", ld_err, 1'b1);
    tick();
    chk("ld_err_clear", ld_err, 1'b0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;

    // Breakpoint: run from PC0 and stop exactly at BPA.
    rst = 1'b1; #1; rst = 1'b0; tick();
    bp_en = 1'b1; bp_addr = BPA;
    run_req = 1'b1; tick(); run_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (state == 2'b00) done = 1'b1;
      else tick();
    end
    chk("bp_halted", {31'd0, done}, 64'd1);
    chk("bp_pc", pc, BPA);
    chk("bp_hit_set", bp_hit, 1'b1);
    run_req = 1'b1; tick(); run_req = 1'b0; #1;
    chk("bp_hit_cleared", bp_hit, 1'b0);
    chk("bp_resume_en", cpu_en, 1'b1);
    tick();
    chk("bp_pc_past", pc, BPA + 32'd4);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    bp_en = 1'b0;

    // All three requests at once in HALT: halt wins.
    halt_req = 1'b1; step_req = 1'b1; run_req = 1'b1; step_cnt = 16'd2; #1;
    chk("prio_en", cpu_en, 1'b0);
    tick();
    halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0; #1;
    chk("prio_state", state, 2'b00);

    // Asynchronous reset in the middle of a step.
    step_cnt = 16'd5; step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("pre_rst_state", state, 2'b10);
    rst = 1'b1; #1;
    chk("arst_state", state, 2'b00);
    chk("arst_cpu_en", cpu_en, 1'b0);
    chk("arst_bp_hit", bp_hit, 1'b0);
    chk("arst_cnt", cycle_cnt, '0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
